uartrx_router: RTL and testbench

Owns the single UART receive byte stream and shares it between three consumers: the CPU console, the serial boot loader and the board-level reset generator. Sits directly behind the UART receiver in the top level. Every byte goes to exactly one of:
- the console FIFO (normal mode);
- the boot loader (boot mode);
- nowhere (during a reset pulse).

Magic-character runs switch between modes, so the board can be reset and reloaded from the host without touching buttons.

---
 rtl/uartrx_router_pkg.sv | 17 +
 rtl/uartrx_fifo.sv | 58 +++++
 rtl/uartrx_router.sv | 149 ++++++++++++++
 tb/tb_uartrx_router.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uartrx_router_pkg.sv
// Shared definitions for the UART receive router and the serial boot loader.
package uartrx_router_pkg;

  typedef enum logic [1:0] {
    CONSOLE   = 2'd0,
    BOOT      = 2'd1,
    RESETTING = 2'd2
  } state_t;

  localparam logic [7:0] DEF_RESET_CHAR = 8'd82;  // 'R'
  localparam logic [7:0] DEF_BOOT_CHAR  = 8'd66;  // 'B'

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uartrx_fifo.sv
// Show-ahead console FIFO, 8-bit wide, with flush and sticky overflow flag.
module uartrx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       ready,
  input  logic       flush,
  input  logic       clr_ovf,
  output logic [7:0] head_data,
  output logic       valid,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_ok;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = ready && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push_ok   = push && (!full || pop);
  assign valid     = !empty;
  assign head_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointers and overflow flag; an overflow set beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_ovf)         overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uartrx_router.sv
// Routes the UART receive stream to the console FIFO, the boot loader, or
// nowhere while a board reset pulse is being generated.
//
// state     | meaning
// CONSOLE   | bytes to console FIFO, magic-run detection active
// BOOT      | bytes to boot loader, idle timeout running
// RESETTING | sys_rst high, bytes dropped, FIFO flushed
module uartrx_router
  import uartrx_router_pkg::*;
#(
  parameter logic [7:0] RESET_CHARACTER = DEF_RESET_CHAR,
  parameter int         RESET_COUNT     = 10,
  parameter logic [7:0] BOOT_CHARACTER  = DEF_BOOT_CHAR,
  parameter int         BOOT_COUNT      = 10,
  parameter int         RST_PULSE       = 1024,
  parameter int         BOOT_TIMEOUT    = 50_000_000,
  parameter int         FIFO_DEPTH      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] con_data,
  output logic       con_valid,
  input  logic       con_ready,
  output logic       con_overflow,
  input  logic       con_clr,
  output logic [7:0] boot_data,
  output logic       boot_valid,
  input  logic       boot_done,
  output logic       boot_active,
  output logic       sys_rst
);

  localparam int CNT_W   = $clog2(max_int(RESET_COUNT, BOOT_COUNT) + 1);
  localparam int PULSE_W = $clog2(RST_PULSE + 1);
  localparam int IDLE_W  = $clog2(BOOT_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RESET_COUNT - 1);
  localparam logic [CNT_W-1:0]   BOOT_LAST  = CNT_W'(BOOT_COUNT - 1);
  localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(RST_PULSE - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LOAD  = IDLE_W'(BOOT_TIMEOUT);
  localparam logic [IDLE_W-1:0]  IDLE_ONE   = IDLE_W'(1);

  state_t             state;
  logic [CNT_W-1:0]   rst_cnt;
  logic [CNT_W-1:0]   boot_cnt;
  logic [PULSE_W-1:0] pulse_cnt;
  logic [IDLE_W-1:0]  idle_cnt;

  logic fifo_push;
  logic fifo_flush;

  assign fifo_push  = rx_valid && (state == CONSOLE);
  assign fifo_flush = (state == RESETTING);

  uartrx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (rx_data),
    .ready     (con_ready),
    .flush     (fifo_flush),
    .clr_ovf   (con_clr),
    .head_data (con_data),
    .valid     (con_valid),
    .overflow  (con_overflow)
  );

  // Mode FSM with run counters, reset-pulse and boot-idle down-counters.
  // Run counters stop at COUNT-1 because the next match fires the trigger
  // and clears them, so they can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CONSOLE;
      rst_cnt     <= '0;
      boot_cnt    <= '0;
      pulse_cnt   <= '0;
      idle_cnt    <= '0;
      boot_data   <= 8'h00;
      boot_valid  <= 1'b0;
      boot_active <= 1'b0;
      sys_rst     <= 1'b0;
    end else begin
      boot_valid <= 1'b0;
      case (state)
        CONSOLE: begin
          if (rx_valid) begin
            if (rx_data == RESET_CHARACTER) begin
              boot_cnt <= '0;
              if (rst_cnt == RST_LAST) begin
                rst_cnt   <= '0;
                pulse_cnt <= PULSE_LOAD;
                sys_rst   <= 1'b1;
                state     <= RESETTING;
              end else begin
                rst_cnt <= rst_cnt + CNT_W'(1);
              end
            end else if (rx_data == BOOT_CHARACTER) begin
              rst_cnt <= '0;
              if (boot_cnt == BOOT_LAST) begin
                boot_cnt    <= '0;
                idle_cnt    <= IDLE_LOAD;
                boot_active <= 1'b1;
                state       <= BOOT;
              end else begin
                boot_cnt <= boot_cnt + CNT_W'(1);
              end
            end else begin
              rst_cnt  <= '0;
              boot_cnt <= '0;
            end
          end
        end
        BOOT: begin
          if (rx_valid) begin
            boot_valid <= 1'b1;
            boot_data  <= rx_data;
          end
          if (boot_done) begin
            boot_active <= 1'b0;
            state       <= CONSOLE;
          end else if (rx_valid) begin
            idle_cnt <= IDLE_LOAD;
          end else if (idle_cnt == IDLE_ONE) begin
            boot_active <= 1'b0;
            state       <= CONSOLE;
          end else begin
            idle_cnt <= idle_cnt - IDLE_ONE;
          end
        end
        RESETTING: begin
          if (pulse_cnt == '0) begin
            sys_rst <= 1'b0;
            state   <= CONSOLE;
          end else begin
            pulse_cnt <= pulse_cnt - PULSE_W'(1);
          end
        end
        default: begin
          sys_rst     <= 1'b0;
          boot_active <= 1'b0;
          state       <= CONSOLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uartrx_router.sv
// Directed self-checking bench for uartrx_router (BOOT_TIMEOUT shortened to 100).
module tb_uartrx_router;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] con_data;
  logic       con_valid;
  logic       con_ready;
  logic       con_overflow;
  logic       con_clr;
  logic [7:0] boot_data;
  logic       boot_valid;
  logic       boot_done;
  logic       boot_active;
  logic       sys_rst;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uartrx_router #(.BOOT_TIMEOUT(100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .con_data     (con_data),
    .con_valid    (con_valid),
    .con_ready    (con_ready),
    .con_overflow (con_overflow),
    .con_clr      (con_clr),
    .boot_data    (boot_data),
    .boot_valid   (boot_valid),
    .boot_done    (boot_done),
    .boot_active  (boot_active),
    .sys_rst      (sys_rst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, {31'd0, con_valid}, 32'd1);
    chk(tag, {24'd0, con_data}, {24'd0, exp});
    con_ready = 1'b1;
    tick();
    con_ready = 1'b0;
  endtask

  // Counts consecutive sys_rst-high cycles starting from the current one.
  task automatic measure_pulse(input int already, output int n);
    n = already;
    for (int i = 0; i < 2000 && sys_rst; i++) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] b;
    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    con_ready = 1'b0;
    con_clr   = 1'b0;
    boot_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_con_valid",   {31'd0, con_valid},    32'd0);
    chk("rst_con_ovf",     {31'd0, con_overflow}, 32'd0);
    chk("rst_boot_valid",  {31'd0, boot_valid},   32'd0);
    chk("rst_boot_active", {31'd0, boot_active},  32'd0);
    chk("rst_sys_rst",     {31'd0, sys_rst},      32'd0);
    chk("rst_con_data",    {24'd0, con_data},     32'd0);
    chk("rst_boot_data",   {24'd0, boot_data},    32'd0);
    rst_n = 1'b1;
    tick();

    // Overflow: nine bytes into an eight-entry FIFO.
    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("ovf_set",   {31'd0, con_overflow}, 32'd1);
    chk("ovf_head",  {24'd0, con_data},     32'h01);
    con_clr = 1'b1;
    tick();
    con_clr = 1'b0;
    chk("ovf_clr",   {31'd0, con_overflow}, 32'd0);
    rx_data   = 8'h0A;
    rx_valid  = 1'b1;
    con_ready = 1'b1;
    tick();
    rx_valid  = 1'b0;
    con_ready = 1'b0;
    chk("pushpop_no_ovf", {31'd0, con_overflow}, 32'd0);
    for (int i = 2; i <= 8; i++) pop("ovf_drain", 8'(i));
    pop("ovf_drain_last", 8'h0A);
    chk("ovf_empty", {31'd0, con_valid}, 32'd0);

    // Broken reset run: nothing fires, all bytes reach the console in order.
    for (int i = 0; i < 19; i++) begin
      b = (i == 9) ? 8'h78 : 8'h52;
      send(b);
      chk("broken_sys_rst", {31'd0, sys_rst}, 32'd0);
      pop("broken_byte", b);
    end

    // Boot entry, then an 'R' run must go to the boot loader only.
    for (int i = 0; i < 10; i++) begin
      send(8'h42);
      if (i == 9) chk("boot_enter", {31'd0, boot_active}, 32'd1);
      pop("boot_magic_pushed", 8'h42);
    end
    for (int i = 0; i < 20; i++) begin
      send(8'h52);
      chk("boot_strobe", {31'd0, boot_valid}, 32'd1);
      chk("boot_byte",   {24'd0, boot_data},  32'h52);
    end
    tick();
    chk("boot_strobe_end", {31'd0, boot_valid},  32'd0);
    chk("boot_no_sys_rst", {31'd0, sys_rst},     32'd0);
    chk("boot_fifo_empty", {31'd0, con_valid},   32'd0);
    chk("boot_still",      {31'd0, boot_active}, 32'd1);
    rx_data   = 8'h33;
    rx_valid  = 1'b1;
    boot_done = 1'b1;
    tick();
    rx_valid  = 1'b0;
    boot_done = 1'b0;
    chk("done_exit",       {31'd0, boot_active}, 32'd0);
    chk("done_last_valid", {31'd0, boot_valid},  32'd1);
    chk("done_last_byte",  {24'd0, boot_data},   32'h33);
    tick();
    chk("done_no_console", {31'd0, con_valid},   32'd0);

    // Boot idle timeout of 100 cycles.
    for (int i = 0; i < 10; i++) begin
      send(8'h42);
      if (i == 9) chk("to_enter", {31'd0, boot_active}, 32'd1);
      pop("to_magic_pushed", 8'h42);
    end
    repeat (98) tick();
    chk("to_before", {31'd0, boot_active}, 32'd1);
    tick();
    chk("to_after",  {31'd0, boot_active}, 32'd0);
    send(8'h41);
    pop("to_console_byte", 8'h41);

    // Reset run: 1024-cycle pulse, bytes during the pulse vanish.
    for (int i = 0; i < 10; i++) begin
      send(8'h52);
      if (i < 9) pop("rr_byte", 8'h52);
    end
    chk("rr_sys_rst_on", {31'd0, sys_rst}, 32'd1);
    send(8'h55);
    chk("rr_drop_boot", {31'd0, boot_valid}, 32'd0);
    chk("rr_drop_con",  {31'd0, con_valid},  32'd0);
    measure_pulse(1, n);
    chk("rr_pulse_len", 32'(n),            32'd1024);
    chk("rr_after_fifo", {31'd0, con_valid},    32'd0);
    chk("rr_after_ovf",  {31'd0, con_overflow}, 32'd0);
    chk("rr_after_boot", {31'd0, boot_active},  32'd0);

    // Async reset in the middle of a pulse.
    for (int i = 0; i < 10; i++) begin
      send(8'h52);
      if (i < 9) pop("ar_byte", 8'h52);
    end
    repeat (499) tick();
    chk("ar_mid_pulse", {31'd0, sys_rst}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_sys_rst_off", {31'd0, sys_rst},     32'd0);
    chk("ar_boot_active", {31'd0, boot_active}, 32'd0);
    chk("ar_con_valid",   {31'd0, con_valid},   32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      send(8'h52);
      if (i < 9) pop("ar2_byte", 8'h52);
    end
    chk("ar2_sys_rst_on", {31'd0, sys_rst}, 32'd1);
    measure_pulse(0, n);
    chk("ar2_pulse_len", 32'(n), 32'd1024);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
